// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC lane array.
//   ACC_W       accumulator width shared with the downstream adder tree
//   ACC_MAX     saturation ceiling of every lane accumulator
//   mac_state_t window-control FSM states
//   acc_t       one lane's accumulated result
package mac_pkg;

    localparam int unsigned ACC_W = 12;
    localparam logic [ACC_W-1:0] ACC_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } mac_state_t;

    typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one multiply-accumulate lane with a saturating 12-bit accumulator.
//   clk    rising-edge clock
//   rst    synchronous reset, active-high; clears the accumulator
//   clear  start of a new window; zeroes the accumulator (wins over en)
//   en     accept one (data, weight) beat
//   data   unsigned activation
//   weight unsigned weight
//   acc    current accumulated value
module mac_lane
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned WGT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    input  logic [WGT_W-1:0]  weight,
    output acc_t              acc
);

    localparam int unsigned PROD_W = DATA_W + WGT_W;

    logic [PROD_W-1:0] prod;
    logic [ACC_W:0]    sum;
    acc_t              acc_q;
    acc_t              acc_d;

    assign prod = PROD_W'(data) * PROD_W'(weight);
    // One spare bit catches the carry so the sum clamps instead of wrapping.
    assign sum  = {1'b0, acc_q} + (ACC_W + 1)'(prod);

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mac_array.sv
// mac_array: N parallel MAC lanes accumulating one K_LEN-beat kernel window, then holding
// the per-lane sums with out_valid until the downstream adder tree accepts them.
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      pulse: begin a new window (honoured in IDLE, or in DONE with out_ready)
//   in_valid   data_in/weight_in beat valid
//   in_ready   high while accumulating; a beat is taken on in_valid && in_ready
//   data_in    per-lane activation
//   weight_in  per-lane weight
//   out_valid  mac_outs holds a finished window
//   out_ready  downstream accepts mac_outs
//   mac_outs   per-lane accumulated sums, retained until the next window starts
//   busy       high whenever the FSM is not idle
module mac_array
    import mac_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned WGT_W  = 4,
    parameter int unsigned K_LEN  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in   [0:N-1],
    input  logic [WGT_W-1:0]  weight_in [0:N-1],
    output logic              out_valid,
    input  logic              out_ready,
    output acc_t              mac_outs  [0:N-1],
    output logic              busy
);

    // K_LEN == 1 would give a zero-width counter; keep at least one bit.
    localparam int unsigned CNT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(K_LEN - 1);

    mac_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             beat;
    logic             clear;

    assign beat  = in_valid && (state == ACCUM);
    // Lanes clear on the same edge the FSM enters ACCUM.
    assign clear = start && ((state == IDLE) || ((state == DONE) && out_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        cnt   <= '0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt == LAST_BEAT) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= start ? ACCUM : IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);

    for (genvar i = 0; i < int'(N); i++) begin : g_lane
        mac_lane #(
            .DATA_W (DATA_W),
            .WGT_W  (WGT_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear),
            .en     (beat),
            .data   (data_in[i]),
            .weight (weight_in[i]),
            .acc    (mac_outs[i])
        );
    end

endmodule

// File: tb/tb_mac_array.sv
module tb_mac_array;

    localparam int unsigned N = 4;
    localparam int unsigned K = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: N=4, K_LEN=9, 4-bit operands.
    logic        start, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]  data_in   [0:N-1];
    logic [3:0]  weight_in [0:N-1];
    logic [11:0] mac_outs  [0:N-1];

    // K_LEN=16 instance with 6-bit operands so the accumulator can be driven past 4095.
    logic        w_start, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
    logic [5:0]  w_data   [0:1];
    logic [5:0]  w_weight [0:1];
    logic [11:0] w_outs   [0:1];

    // K_LEN=1 instance.
    logic        s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [3:0]  s_data   [0:0];
    logic [3:0]  s_weight [0:0];
    logic [11:0] s_outs   [0:0];

    mac_array #(.N(N), .DATA_W(4), .WGT_W(4), .K_LEN(K)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .weight_in(weight_in), .out_valid(out_valid),
        .out_ready(out_ready), .mac_outs(mac_outs), .busy(busy)
    );

    mac_array #(.N(2), .DATA_W(6), .WGT_W(6), .K_LEN(16)) dut_w (
        .clk(clk), .rst(rst), .start(w_start), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .data_in(w_data), .weight_in(w_weight), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .mac_outs(w_outs), .busy(w_busy)
    );

    mac_array #(.N(1), .DATA_W(4), .WGT_W(4), .K_LEN(1)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .data_in(s_data), .weight_in(s_weight), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .mac_outs(s_outs), .busy(s_busy)
    );

    int checks = 0;
    int errors = 0;

    // Beat stimulus for the main instance: bd/bw[beat][lane].
    int unsigned bd [16][N];
    int unsigned bw [16][N];

    typedef struct {
        int unsigned d;
        int unsigned w;
        int unsigned exp;
        int          mode;   // 0: in_valid held, 1: toggled, 2: random gaps
    } vec_t;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Window result straight from the arithmetic: sum of products, clamped at 4095.
    function automatic int unsigned ref_acc(input int lane, input int nbeats);
        int unsigned s = 0;
        for (int b = 0; b < nbeats; b++) s += bd[b][lane] * bw[b][lane];
        return (s > 4095) ? 4095 : s;
    endfunction

    task automatic run_window(input int mode);
        int  b = 0;
        int  t = 0;
        int  cyc;
        logic v;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (b < int'(K) && t < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (t % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            in_valid = v;
            // A mid-window start must be ignored.
            start = (mode == 1 && t == 4);
            for (int i = 0; i < int'(N); i++) begin
                data_in[i]   = v ? 4'(bd[b][i]) : 4'($urandom);
                weight_in[i] = v ? 4'(bw[b][i]) : 4'($urandom);
            end
            step();
            cyc++;
            t++;
            if (v) b++;
            if (b < int'(K)) begin
                check("in_ready in ACCUM", 32'(in_ready), 1);
                check("out_valid before last beat", 32'(out_valid), 0);
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("beats delivered", b, K);
        check("out_valid after last beat", 32'(out_valid), 1);
        check("in_ready in DONE", 32'(in_ready), 0);
        if (mode == 0) check("start-to-out_valid cycles", cyc, 10);
        for (int i = 0; i < int'(N); i++) check("mac_outs window", mac_outs[i], ref_acc(i, K));
    endtask

    task automatic accept(input int delay);
        out_ready = 1'b0;
        for (int k = 0; k < delay; k++) begin
            step();
            check("out_valid held", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid after accept", 32'(out_valid), 0);
        check("busy after accept", 32'(busy), 0);
    endtask

    vec_t vecs [6];
    int unsigned held [N];

    initial begin
        rst = 1'b1;
        start = 0; in_valid = 0; out_ready = 0;
        w_start = 0; w_in_valid = 0; w_out_ready = 0;
        s_start = 0; s_in_valid = 0; s_out_ready = 0;
        for (int i = 0; i < int'(N); i++) begin data_in[i] = 0; weight_in[i] = 0; end
        for (int i = 0; i < 2; i++) begin w_data[i] = 0; w_weight[i] = 0; end
        s_data[0] = 0; s_weight[0] = 0;
        step();
        step();
        rst = 1'b0;

        check("reset busy", 32'(busy), 0);
        check("reset in_ready", 32'(in_ready), 0);
        check("reset out_valid", 32'(out_valid), 0);
        for (int i = 0; i < int'(N); i++) check("reset mac_outs", mac_outs[i], 0);

        vecs[0] = '{d: 3,  w: 2,  exp: 54,   mode: 0};
        vecs[1] = '{d: 3,  w: 2,  exp: 54,   mode: 1};
        vecs[2] = '{d: 15, w: 15, exp: 2025, mode: 0};
        vecs[3] = '{d: 0,  w: 9,  exp: 0,    mode: 2};
        vecs[4] = '{d: 1,  w: 1,  exp: 9,    mode: 1};
        vecs[5] = '{d: 7,  w: 9,  exp: 567,  mode: 0};
        foreach (vecs[r]) begin
            for (int b = 0; b < 16; b++)
                for (int i = 0; i < int'(N); i++) begin bd[b][i] = vecs[r].d; bw[b][i] = vecs[r].w; end
            run_window(vecs[r].mode);
            for (int i = 0; i < int'(N); i++) check("table result", mac_outs[i], vecs[r].exp);
            accept(r % 3);
        end

        // Results are retained in IDLE and in_valid is ignored there.
        for (int i = 0; i < int'(N); i++) begin data_in[i] = 15; weight_in[i] = 15; end
        in_valid = 1'b1;
        step(); step(); step();
        in_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) check("IDLE retains result", mac_outs[i], 567);
        check("IDLE in_ready", 32'(in_ready), 0);

        // DONE hold with out_ready low; start there ignored; then out_ready+start restarts.
        for (int b = 0; b < 16; b++)
            for (int i = 0; i < int'(N); i++) begin bd[b][i] = 3; bw[b][i] = 2; end
        run_window(0);
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            step();
            check("DONE out_valid stable", 32'(out_valid), 1);
            check("DONE busy", 32'(busy), 1);
            check("DONE in_ready", 32'(in_ready), 0);
            for (int i = 0; i < int'(N); i++) check("DONE mac_outs stable", mac_outs[i], 54);
        end
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        check("restart in_ready", 32'(in_ready), 1);
        check("restart out_valid", 32'(out_valid), 0);
        for (int i = 0; i < int'(N); i++) check("restart cleared", mac_outs[i], 0);

        // Abandon mid-window with rst after four beats.
        in_valid = 1'b1;
        for (int i = 0; i < int'(N); i++) begin data_in[i] = 3; weight_in[i] = 2; end
        for (int k = 0; k < 4; k++) step();
        in_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) check("four beats", mac_outs[i], 24);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst busy", 32'(busy), 0);
        check("rst in_ready", 32'(in_ready), 0);
        check("rst out_valid", 32'(out_valid), 0);
        for (int i = 0; i < int'(N); i++) check("rst mac_outs", mac_outs[i], 0);

        // Randomized windows against the arithmetic model.
        for (int n = 0; n < 20; n++) begin
            for (int b = 0; b < 16; b++)
                for (int i = 0; i < int'(N); i++) begin
                    bd[b][i] = $urandom_range(0, 15);
                    bw[b][i] = $urandom_range(0, 15);
                end
            run_window(2);
            accept($urandom_range(0, 3));
        end

        // K_LEN=16: saturation with 63*63 beats, then 15*15 -> 3600.
        for (int i = 0; i < 2; i++) begin w_data[i] = 63; w_weight[i] = 63; end
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        w_in_valid = 1'b1;
        step();
        for (int i = 0; i < 2; i++) check("wide first beat", w_outs[i], 3969);
        step();
        for (int i = 0; i < 2; i++) check("wide saturate", w_outs[i], 4095);
        for (int k = 0; k < 14; k++) step();
        w_in_valid = 1'b0;
        check("wide out_valid", 32'(w_out_valid), 1);
        for (int i = 0; i < 2; i++) check("wide clamp held", w_outs[i], 4095);
        w_out_ready = 1'b1;
        w_start = 1'b1;
        for (int i = 0; i < 2; i++) begin w_data[i] = 15; w_weight[i] = 15; end
        step();
        w_out_ready = 1'b0;
        w_start = 1'b0;
        check("wide restart in_ready", 32'(w_in_ready), 1);
        w_in_valid = 1'b1;
        for (int k = 0; k < 15; k++) step();
        check("wide not done at 15", 32'(w_out_valid), 0);
        step();
        w_in_valid = 1'b0;
        check("wide done at 16", 32'(w_out_valid), 1);
        check("wide busy", 32'(w_busy), 1);
        for (int i = 0; i < 2; i++) check("wide 3600", w_outs[i], 3600);

        // K_LEN=1: one beat goes straight to DONE.
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        check("single in_ready", 32'(s_in_ready), 1);
        s_in_valid = 1'b1;
        s_data[0] = 5;
        s_weight[0] = 7;
        step();
        s_in_valid = 1'b0;
        check("single out_valid", 32'(s_out_valid), 1);
        check("single result", s_outs[0], 35);
        s_out_ready = 1'b1;
        step();
        s_out_ready = 1'b0;
        check("single idle", 32'(s_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
